// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the reg_file write port between requesters A and B.
// Optional combinational read forwarding of the in-flight write: define REGARB_BYPASS_EN.
module reg_file_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
`ifdef REGARB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
`endif
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
);

  logic                  r_bufa_v;
  logic [ADDR_WIDTH-1:0] r_bufa_addr;
  logic [DATA_WIDTH-1:0] r_bufa_data;
  logic                  r_bufb_v;
  logic [ADDR_WIDTH-1:0] r_bufb_addr;
  logic [DATA_WIDTH-1:0] r_bufb_data;
  logic                  r_ptr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_acc_a;
  logic                  w_acc_b;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  assign a_ready = rst & ~r_bufa_v;
  assign b_ready = rst & ~r_bufb_v;
  assign w_acc_a = a_valid & a_ready;
  assign w_acc_b = b_valid & b_ready;

  // r_ptr=0 favours A when both buffers hold an entry
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    if (r_bufa_v && (!r_bufb_v || !r_ptr)) begin
      w_grant_a  = 1'b1;
      w_gnt_addr = r_bufa_addr;
      w_gnt_data = r_bufa_data;
    end else if (r_bufb_v) begin
      w_grant_b  = 1'b1;
      w_gnt_addr = r_bufb_addr;
      w_gnt_data = r_bufb_data;
    end
  end

  assign w_grant = w_grant_a | w_grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bufa_v    <= 1'b0;
      r_bufa_addr <= '0;
      r_bufa_data <= '0;
      r_bufb_v    <= 1'b0;
      r_bufb_addr <= '0;
      r_bufb_data <= '0;
      r_ptr       <= 1'b0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      // accept and drain are exclusive: ready is low while a buffer is full
      if (w_acc_a) begin
        r_bufa_v    <= 1'b1;
        r_bufa_addr <= a_addr;
        r_bufa_data <= a_data;
      end else if (w_grant_a) begin
        r_bufa_v <= 1'b0;
      end
      if (w_acc_b) begin
        r_bufb_v    <= 1'b1;
        r_bufb_addr <= b_addr;
        r_bufb_data <= b_data;
      end else if (w_grant_b) begin
        r_bufb_v <= 1'b0;
      end
      if (w_grant_a)
        r_ptr <= 1'b1;
      else if (w_grant_b)
        r_ptr <= 1'b0;
      // an address-0 grant still consumes its slot but never raises wen
      r_wen <= w_grant && (w_gnt_addr != '0);
      if (w_grant) begin
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign busy  = r_bufa_v | r_bufb_v | r_wen;

`ifdef REGARB_BYPASS_EN
  // only the write in flight is forwarded; buffered entries are not visible
  assign rdata1 = (r_wen && (r_waddr == raddr1)) ? r_wdata : rf_rdata1;
  assign rdata2 = (r_wen && (r_waddr == raddr2)) ? r_wdata : rf_rdata2;
`endif

endmodule
